// File: rtl/vga_pkg.sv
// Shared widths and the one-hot issue-type encoding for the VGA memory arbiter.
package vga_pkg;

    localparam int VGA_AW = 12;
    localparam int VGA_DW = 16;

    // Registered record of which access owns the RAM read port this cycle.
    typedef enum logic [3:0] {
        ISS_NONE    = 4'b0001,
        ISS_DISP_RD = 4'b0010,
        ISS_CPU_RD  = 4'b0100,
        ISS_CPU_WR  = 4'b1000
    } iss_e;

endpackage

// File: rtl/vga_req_fifo.sv
// Small synchronous FIFO holding queued CPU requests ahead of the RAM port.
module vga_req_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port video RAM arbiter: display fetches always win, CPU requests queue
// in a FIFO and drain in order on free cycles, with a starvation flag.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int AW           = VGA_AW,
    parameter int DW           = VGA_DW,
    parameter int DEPTH        = 2,
    parameter int BLANK_ONLY   = 0,
    parameter int STARVE_LIMIT = 800
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          activevideo_i,
    input  logic          fetch_req_i,
    input  logic [AW-1:0] fetch_addr_i,
    output logic          fetch_valid_o,
    output logic [DW-1:0] fetch_data_o,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ready_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          starve_o
);

    localparam int EW = 1 + AW + DW;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0] head;
    logic          fifo_full, fifo_empty;
    logic          cpu_issue;
    logic          head_we;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_wdata;
    iss_e          iss_q, iss_d;
    logic [SW-1:0] starve_q, starve_d;

    vga_req_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (cpu_req_i),
        .data_i  ({cpu_we_i, cpu_addr_i, cpu_wdata_i}),
        .pop_i   (cpu_issue),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_we    = head[EW-1];
    assign head_addr  = head[EW-2 -: AW];
    assign head_wdata = head[DW-1:0];

    // Ready comes only from registered occupancy, so a same-cycle pop never frees a slot.
    assign cpu_ready_o = !fifo_full;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        cpu_issue   = 1'b0;
        iss_d       = ISS_NONE;
        if (fetch_req_i) begin
            mem_en_o   = 1'b1;
            mem_addr_o = fetch_addr_i;
            iss_d      = ISS_DISP_RD;
        end else if (!fifo_empty && ((BLANK_ONLY == 0) || !activevideo_i)) begin
            cpu_issue   = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = head_we;
            mem_addr_o  = head_addr;
            mem_wdata_o = head_we ? head_wdata : '0;
            iss_d       = head_we ? ISS_CPU_WR : ISS_CPU_RD;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || cpu_issue)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            iss_q    <= ISS_NONE;
            starve_q <= '0;
        end else begin
            iss_q    <= iss_d;
            starve_q <= starve_d;
        end
    end

    assign fetch_valid_o = (iss_q == ISS_DISP_RD);
    assign fetch_data_o  = fetch_valid_o ? mem_rdata_i : '0;
    assign cpu_rvalid_o  = (iss_q == ISS_CPU_RD);
    assign cpu_rdata_o   = cpu_rvalid_o ? mem_rdata_i : '0;
    assign starve_o      = (starve_q == SW'(STARVE_LIMIT));

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench: two arbiter configurations share one stimulus stream, each
// checked against a queue-level reference model and its own behavioural RAM.
module tb_vga_mem_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LIM = 8;

    typedef struct {
        int            stamp;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk = 1'b0;
    logic          rstn, av, fetch_req, cpu_req, cpu_we;
    logic [AW-1:0] fetch_addr, cpu_addr;
    logic [DW-1:0] cpu_wdata;
    int            cyc   = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 37) ^ 'h5A5A);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int BO  = g;
        localparam int DEP = (g == 0) ? 2 : 4;

        logic          fv, crv, rdy, starve, men, mwe;
        logic [DW-1:0] fd, crd, mwd, mrd;
        logic [AW-1:0] ma;
        logic [DW-1:0] ram     [1 << AW];
        logic [DW-1:0] ref_mem [1 << AW];

        req_t  q[$];
        rsp_t  fq[$], cq[$];
        int    wait_n = 0;
        bit    inited = 1'b0;

        initial begin
            mrd = '0;
            for (int i = 0; i < (1 << AW); i++) begin
                ram[i]     = init_val(i);
                ref_mem[i] = init_val(i);
            end
        end

        always @(posedge clk) begin
            if (men) begin
                if (mwe) ram[ma] <= mwd;
                else     mrd     <= ram[ma];
            end
        end

        vga_mem_arbiter #(
            .AW           (AW),
            .DW           (DW),
            .DEPTH        (DEP),
            .BLANK_ONLY   (BO),
            .STARVE_LIMIT (LIM)
        ) u_dut (
            .clk_i         (clk),
            .rstn_i        (rstn),
            .activevideo_i (av),
            .fetch_req_i   (fetch_req),
            .fetch_addr_i  (fetch_addr),
            .fetch_valid_o (fv),
            .fetch_data_o  (fd),
            .cpu_req_i     (cpu_req),
            .cpu_we_i      (cpu_we),
            .cpu_addr_i    (cpu_addr),
            .cpu_wdata_i   (cpu_wdata),
            .cpu_ready_o   (rdy),
            .cpu_rvalid_o  (crv),
            .cpu_rdata_o   (crd),
            .mem_en_o      (men),
            .mem_we_o      (mwe),
            .mem_addr_o    (ma),
            .mem_wdata_o   (mwd),
            .mem_rdata_i   (mrd),
            .starve_o      (starve)
        );

        // Response monitor: a response is owed exactly one cycle after its issue.
        always @(negedge clk) begin
            rsp_t r;
            bit   ev;
            #1;
            if (inited) begin
                ev = (fq.size() > 0) && (fq[0].stamp == cyc - 1);
                chk($sformatf("i%0d.fetch_valid", g), fv, ev);
                if (ev) begin
                    r = fq.pop_front();
                    chk($sformatf("i%0d.fetch_data", g), fd, r.data);
                end else begin
                    chk($sformatf("i%0d.fetch_data_idle", g), fd, 0);
                end
                ev = (cq.size() > 0) && (cq[0].stamp == cyc - 1);
                chk($sformatf("i%0d.cpu_rvalid", g), crv, ev);
                if (ev) begin
                    r = cq.pop_front();
                    chk($sformatf("i%0d.cpu_rdata", g), crd, r.data);
                end else begin
                    chk($sformatf("i%0d.cpu_rdata_idle", g), crd, 0);
                end
            end
        end

        // Reference model: one step per clock, evaluated on settled inputs.
        always @(negedge clk) begin
            req_t          h;
            rsp_t          r;
            bit            e_rdy, e_en, e_we, popped, was_empty;
            logic [AW-1:0] e_a;
            logic [DW-1:0] e_wd;
            #2;
            if (!inited) begin
                if (!rstn) begin
                    inited = 1'b1;
                    q.delete(); fq.delete(); cq.delete();
                    wait_n = 0;
                end
            end else begin
                e_rdy     = (q.size() < DEP);
                was_empty = (q.size() == 0);
                chk($sformatf("i%0d.cpu_ready", g), rdy, e_rdy);
                chk($sformatf("i%0d.starve", g), starve, (wait_n >= LIM));
                e_en = 0; e_we = 0; e_a = '0; e_wd = '0; popped = 0;
                if (fetch_req) begin
                    e_en = 1; e_a = fetch_addr;
                    r.stamp = cyc; r.data = ref_mem[fetch_addr];
                    fq.push_back(r);
                end else if (!was_empty && (BO == 0 || !av)) begin
                    h = q.pop_front();
                    popped = 1; e_en = 1; e_we = h.we; e_a = h.addr;
                    if (h.we) begin
                        e_wd = h.wdata;
                        ref_mem[h.addr] = h.wdata;
                    end else begin
                        r.stamp = cyc; r.data = ref_mem[h.addr];
                        cq.push_back(r);
                    end
                end
                chk($sformatf("i%0d.mem_en", g), men, e_en);
                chk($sformatf("i%0d.mem_we", g), mwe, e_we);
                chk($sformatf("i%0d.mem_addr", g), ma, e_a);
                chk($sformatf("i%0d.mem_wdata", g), mwd, e_wd);
                if (popped || was_empty) wait_n = 0;
                else if (wait_n < LIM)   wait_n++;
                if (cpu_req && e_rdy) begin
                    h.we = cpu_we; h.addr = cpu_addr; h.wdata = cpu_wdata;
                    q.push_back(h);
                end
                if (!rstn) begin
                    q.delete(); fq.delete(); cq.delete();
                    wait_n = 0;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    initial begin
        rstn = 1'b0; av = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cycles(2);
        rstn = 1'b1;
        cycles(2);

        // CPU write then display read-back of the same word
        cpu(1'b1, 12'h010, 16'hBEEF);
        cycles(1);
        cpu_req = 1'b0;
        cycles(2);
        fetch_req = 1'b1; fetch_addr = 12'h010;
        cycles(1);
        fetch_req = 1'b0;
        cycles(2);

        // Long display burst with two writes queued behind it
        for (int i = 0; i < 20; i++) begin
            fetch_req = 1'b1; fetch_addr = AW'(i);
            if (i < 2) cpu(1'b1, AW'(12'h020 + i), DW'(16'h1111 * (i + 1)));
            else       cpu_req = 1'b0;
            cycles(1);
        end
        fetch_req = 1'b0;
        cycles(3);
        for (int i = 0; i < 2; i++) begin
            fetch_req = 1'b1; fetch_addr = AW'(12'h020 + i);
            cycles(1);
        end
        fetch_req = 1'b0;
        cycles(2);

        // CPU read queued during active video, released at blanking
        av = 1'b1;
        cpu(1'b0, 12'h010, '0);
        cycles(1);
        cpu_req = 1'b0;
        cycles(5);
        av = 1'b0;
        cycles(3);

        // Head blocked past the starvation limit
        fetch_req = 1'b1; fetch_addr = 12'h005;
        cpu(1'b1, 12'h040, 16'hCAFE);
        cycles(1);
        cpu_req = 1'b0;
        cycles(11);
        fetch_req = 1'b0;
        cycles(3);

        // Fill the FIFO with reads, then reset mid-stream
        for (int i = 0; i < 5; i++) begin
            fetch_req = 1'b1; fetch_addr = AW'(i);
            cpu(1'b0, AW'(12'h030 + i), '0);
            cycles(1);
        end
        fetch_req = 1'b0; cpu_req = 1'b0; rstn = 1'b0;
        cycles(1);
        rstn = 1'b1;
        cycles(4);

        // Randomised traffic over a small address window to force hazards
        for (int i = 0; i < 3000; i++) begin
            rstn       = ($urandom_range(0, 399) != 0);
            fetch_req  = ($urandom_range(0, 2) == 0);
            fetch_addr = AW'($urandom_range(0, 31));
            if (i % 50 == 0) av = 1'($urandom_range(0, 1));
            cpu_req    = 1'($urandom_range(0, 1));
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = AW'($urandom_range(0, 31));
            cpu_wdata  = DW'($urandom);
            cycles(1);
        end
        rstn = 1'b1; fetch_req = 1'b0; cpu_req = 1'b0; av = 1'b0;
        cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12, video memory address width.
REQ-002 SHALL have parameter DW, default 16, video memory data width.
REQ-003 SHALL have parameter DEPTH, default 2, CPU request FIFO entries, power of two.
REQ-004 SHALL have parameter BLANK_ONLY, default 0; 1 = CPU accesses issued only while activevideo_i low.
REQ-005 SHALL have parameter STARVE_LIMIT, default 800, cycles a FIFO head may wait before starve_o.
REQ-006 SHALL have port clk_i  in  1  single clock, 25 MHz pixel clock; all logic on rising edge.
REQ-007 SHALL have port rstn_i  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port activevideo_i  in  1  display zone flag from the sync generator.
REQ-009 SHALL have ports fetch_req_i in 1 and fetch_addr_i in AW: display read request, never stalled.
REQ-010 SHALL have ports fetch_valid_o out 1 and fetch_data_o out DW: display read response.
REQ-011 SHALL have ports cpu_req_i in 1, cpu_we_i in 1, cpu_addr_i in AW, cpu_wdata_i in DW: CPU request.
REQ-012 SHALL have port cpu_ready_o  out  1  request accepted when cpu_req_i and cpu_ready_o both high.
REQ-013 SHALL have ports cpu_rvalid_o out 1 and cpu_rdata_o out DW: CPU read response.
REQ-014 SHALL have ports mem_en_o out 1, mem_we_o out 1, mem_addr_o out AW, mem_wdata_o out DW, mem_rdata_i in DW: single-port RAM, read data valid one cycle after mem_en_o with mem_we_o low.
REQ-015 SHALL have port starve_o  out  1  FIFO head waited STARVE_LIMIT cycles.

Function
REQ-016 SHALL grant the RAM to fetch_req_i unconditionally in the same cycle (combinational drive of mem_* outputs).
REQ-017 SHALL issue the FIFO head to the RAM in a cycle when fetch_req_i is low, FIFO non-empty, and (BLANK_ONLY=0 or activevideo_i low); the head pops that cycle.
REQ-018 SHALL drive mem_en_o low when no access is issued; mem_we_o, mem_wdata_o are 0 on non-write cycles.
REQ-019 SHALL record the issued access type in a one-hot issue register {NONE, DISP_RD, CPU_RD, CPU_WR}, updated every cycle.
REQ-020 SHALL assert fetch_valid_o exactly one cycle after a display issue, with fetch_data_o = mem_rdata_i; fetch_data_o is 0 otherwise.
REQ-021 SHALL assert cpu_rvalid_o exactly one cycle after a CPU read issue, with cpu_rdata_o = mem_rdata_i; 0 otherwise; CPU writes produce no response.
REQ-022 SHALL drive cpu_ready_o = (occupancy < DEPTH), from registered occupancy only; a pop in the same cycle does not raise it.
REQ-023 SHALL keep occupancy unchanged on simultaneous push and pop; push ignored when full; pop never issued when empty.
REQ-024 SHALL preserve CPU request order; read/write hazards resolve in issue order.
REQ-025 SHALL count cycles the FIFO head is present but not issued in a saturating counter, cleared on pop or when empty; starve_o high while counter equals STARVE_LIMIT.
REQ-026 SHALL treat fetch_req_i while activevideo_i is low as legal and still prioritise it.

Reset
REQ-027 SHALL, while rstn_i low at a clock edge, clear FIFO occupancy and pointers, issue register to NONE, starve counter to 0.
REQ-028 SHALL hold after reset: cpu_ready_o=1, fetch_valid_o=0, cpu_rvalid_o=0, starve_o=0, all data outputs 0; mem_* outputs follow fetch_req_i only.
REQ-029 SHALL drop responses owed to accesses issued in the cycle reset is applied; queued CPU requests are discarded.

Structure
REQ-030 SHALL place AW, DW defaults and the issue-type encoding in shared package vga_pkg.
REQ-031 SHALL implement the request FIFO as sub-module vga_req_fifo (push/pop/full/empty/head, depth parameter).

Verification
REQ-032 SHALL cover: CPU write addr 0x010 data 0xBEEF, fetch_req_i low -> mem_we_o=1 next edge, later fetch of 0x010 returns 0xBEEF one cycle after request.
REQ-033 SHALL cover: fetch_req_i held high 20 cycles with 2 queued CPU writes -> no CPU issue, cpu_ready_o=0 during hold, both issue in the 2 cycles after release.
REQ-034 SHALL cover: BLANK_ONLY=1, CPU read queued at activevideo_i=1 -> issued first cycle activevideo_i=0, cpu_rvalid_o next cycle.
REQ-035 SHALL cover: STARVE_LIMIT=8, head blocked 8 cycles -> starve_o high at 8th cycle, low the cycle after pop.
REQ-036 SHALL cover: FIFO full, rstn_i low one cycle mid-stream -> occupancy 0, cpu_ready_o=1, no cpu_rvalid_o for flushed reads.
